// File: rtl/text_overlay_mixer.sv
// Text overlay mixer: drives text ROM addresses, delays the scene to match ROM latency and
// overlays opaque text behind a frame-synchronous visibility FSM. Optional blink: TEXT_BLINK_EN.
module text_overlay_mixer #(
    parameter int          ADDR_W       = 16,
    parameter int          ROM_LAT      = 1,
    parameter logic [11:0] KEY_COLOR    = 12'h000,
    parameter int          DELAY_FRAMES = 30,
    parameter int          BLINK_FRAMES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        over,
    input  logic              frame_start,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [11:0]       scene_rgb,
    input  logic              text_hit,
    input  logic [ADDR_W-1:0] text_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [11:0]       rgb_out,
    output logic              de_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic              text_on
);

    localparam int L       = ROM_LAT + 1;
    localparam int PW      = 17;
    localparam int CNT_MAX = (DELAY_FRAMES > 2 * BLINK_FRAMES) ? DELAY_FRAMES : 2 * BLINK_FRAMES;
    localparam int CW      = $clog2((CNT_MAX > 1) ? CNT_MAX : 2) + 1;
    localparam logic [CW-1:0] DLY_LAST = (DELAY_FRAMES > 1) ? CW'(DELAY_FRAMES - 1) : '0;
    localparam logic [CW-1:0] CNT_SAT  = '1;
`ifdef TEXT_BLINK_EN
    localparam logic [CW-1:0] BLINK_LAST = (BLINK_FRAMES > 0) ? CW'(2 * BLINK_FRAMES - 1) : '0;
    localparam logic [CW-1:0] BLINK_HALF = CW'(BLINK_FRAMES);
`endif

    typedef enum logic [1:0] {IDLE, DELAY, SHOW} state_t;

    state_t          r_state, w_state_next;
    logic            r_kind, w_kind_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            r_text_on, w_text_on_next;
    logic            w_phase_on;

    logic [ADDR_W-1:0] r_rom_addr;
    logic [11:0]       r_rgb;
    logic              r_de, r_hs, r_vs;

    logic [PW-1:0] r_pipe [L];
    logic [PW-1:0] w_stage_in;
    logic [PW-1:0] w_tail;
    logic          w_de_d, w_hs_d, w_vs_d, w_hit_d, w_on_d;
    logic [11:0]   w_scene_d;
    logic [11:0]   w_rgb_mix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_kind    <= 1'b0;
            r_cnt     <= '0;
            r_text_on <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_kind    <= w_kind_next;
            r_cnt     <= w_cnt_next;
            r_text_on <= w_text_on_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_kind_next    = r_kind;
        w_cnt_next     = r_cnt;
        w_text_on_next = r_text_on;
        w_phase_on     = 1'b1;
        if (!over[1]) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_kind_next  = over[0];
                    w_cnt_next   = '0;
                    w_state_next = DELAY;
                end
                default: begin
                    // A change between gameover and win restarts the entry delay.
                    if (over[0] != r_kind) begin
                        w_kind_next  = over[0];
                        w_cnt_next   = '0;
                        w_state_next = DELAY;
                    end else if (r_state == DELAY) begin
                        if (frame_start) begin
                            if (r_cnt >= DLY_LAST) begin
                                w_state_next = SHOW;
                                w_cnt_next   = '0;
                            end else if (r_cnt != CNT_SAT) begin
                                w_cnt_next = r_cnt + 1'b1;
                            end
                        end
                    end
`ifdef TEXT_BLINK_EN
                    else if (r_kind && frame_start) begin
                        w_cnt_next = (r_cnt >= BLINK_LAST) ? '0 : r_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
`ifdef TEXT_BLINK_EN
        w_phase_on = !w_kind_next || (w_cnt_next < BLINK_HALF);
`endif
        // Visibility only moves at frame boundaries so a frame is never torn.
        if (frame_start) begin
            w_text_on_next = (w_state_next == SHOW) && w_phase_on;
        end
    end

    assign w_stage_in = {de_in, hs_in, vs_in, text_hit, r_text_on, scene_rgb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tail    = r_pipe[L-1];
    assign w_de_d    = w_tail[16];
    assign w_hs_d    = w_tail[15];
    assign w_vs_d    = w_tail[14];
    assign w_hit_d   = w_tail[13];
    assign w_on_d    = w_tail[12];
    assign w_scene_d = w_tail[11:0];

    always_comb begin
        w_rgb_mix = w_scene_d;
        if (!w_de_d) begin
            w_rgb_mix = 12'h000;
        end else if (w_on_d && w_hit_d && (rom_data != KEY_COLOR)) begin
            w_rgb_mix = rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_rgb      <= '0;
            r_de       <= 1'b0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
        end else begin
            r_rom_addr <= text_addr;
            r_rgb      <= w_rgb_mix;
            r_de       <= w_de_d;
            r_hs       <= w_hs_d;
            r_vs       <= w_vs_d;
        end
    end

    assign rom_addr = r_rom_addr;
    assign rgb_out  = r_rgb;
    assign de_out   = r_de;
    assign hs_out   = r_hs;
    assign vs_out   = r_vs;
    assign text_on  = r_text_on;

endmodule

// File: tb/tb_text_overlay_mixer.sv
// Directed bench for text_overlay_mixer: one instance at ROM_LAT=1 and one at ROM_LAT=3,
// both with DELAY_FRAMES=3 and BLINK_FRAMES=2, each fed by a synchronous ROM model.
module tb_text_overlay_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  over = 2'b00;
    logic        frame_start = 1'b0;
    logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
    logic [11:0] scene_rgb = 12'h000;
    logic        text_hit = 1'b0;
    logic [15:0] text_addr = 16'h0000;

    logic [15:0] rom_addr1, rom_addr3;
    logic [11:0] rom_data1 = 12'h000, rp1 = 12'h000, rp2 = 12'h000, rom_data3 = 12'h000;
    logic [11:0] rgb1, rgb3;
    logic        de1, hs1, vs1, on1, de3, hs3, vs3, on3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] blink_exp;

    always #5 clk = ~clk;

    // ROM content is the low 12 address bits, so address 0 returns the key colour.
    always @(posedge clk) begin
        rom_data1 <= rom_addr1[11:0];
        rp1       <= rom_addr3[11:0];
        rp2       <= rp1;
        rom_data3 <= rp2;
    end

    text_overlay_mixer #(.ADDR_W(16), .ROM_LAT(1), .KEY_COLOR(12'h000),
                         .DELAY_FRAMES(3), .BLINK_FRAMES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .over(over), .frame_start(frame_start),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .scene_rgb(scene_rgb),
        .text_hit(text_hit), .text_addr(text_addr), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .rgb_out(rgb1), .de_out(de1), .hs_out(hs1),
        .vs_out(vs1), .text_on(on1));

    text_overlay_mixer #(.ADDR_W(16), .ROM_LAT(3), .KEY_COLOR(12'h000),
                         .DELAY_FRAMES(3), .BLINK_FRAMES(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .over(over), .frame_start(frame_start),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .scene_rgb(scene_rgb),
        .text_hit(text_hit), .text_addr(text_addr), .rom_addr(rom_addr3),
        .rom_data(rom_data3), .rgb_out(rgb3), .de_out(de3), .hs_out(hs3),
        .vs_out(vs3), .text_on(on3));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic idle_px();
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        scene_rgb = 12'h000; text_hit = 1'b0; text_addr = 16'h0000;
    endtask

    function automatic logic [11:0] px_exp(input int p);
        return p[0] ? 12'(12'h100 + p) : 12'(12'h800 + p);
    endfunction

    initial begin
`ifdef TEXT_BLINK_EN
        blink_exp = 5'b11001;
`else
        blink_exp = 5'b11111;
`endif
        // Reset state, with live-looking inputs held during reset.
        de_in = 1'b1; scene_rgb = 12'hFFF; text_addr = 16'hBEEF;
        tick(); tick(); tick();
        check("rst_rgb", 16'(rgb1), 16'h000);
        check("rst_de", 16'(de1), 16'h0);
        check("rst_text_on", 16'(on1), 16'h0);
        check("rst_rom_addr", rom_addr1, 16'h0000);
        idle_px();
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Latency-2 pipeline with over=00; the hit pixel must stay scene since text is off.
        de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b0; scene_rgb = 12'hABC;
        text_hit = 1'b1; text_addr = 16'h0F00;
        tick();
        check("rom_addr_1clk", rom_addr1, 16'h0F00);
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b1; scene_rgb = 12'h111;
        text_hit = 1'b0; text_addr = 16'h0055;
        tick();
        check("lat_not_early_rgb", 16'(rgb1), 16'h000);
        check("lat_not_early_de", 16'(de1), 16'h0);
        check("rom_addr_next", rom_addr1, 16'h0055);
        idle_px();
        tick();
        check("lat2_rgb", 16'(rgb1), 16'hABC);
        check("lat2_de", 16'(de1), 16'h1);
        check("lat2_hs", 16'(hs1), 16'h1);
        check("lat2_vs", 16'(vs1), 16'h0);
        tick();
        check("blank_rgb", 16'(rgb1), 16'h000);
        check("blank_de", 16'(de1), 16'h0);
        check("blank_hs", 16'(hs1), 16'h0);
        check("blank_vs", 16'(vs1), 16'h1);

        // Gameover entry: visible at the third frame_start after entering DELAY.
        over = 2'b10;
        tick();
        frame(); check("go_delay_f1", 16'(on1), 16'h0);
        frame(); check("go_delay_f2", 16'(on1), 16'h0);
        frame(); check("go_show_f3", 16'(on1), 16'h1);
        check("go_show_f3_lat3", 16'(on3), 16'h1);

        // Overlay mixing: opaque text, key colour, then outside the rectangle.
        de_in = 1'b1; scene_rgb = 12'h0AA; text_hit = 1'b1; text_addr = 16'h0F00;
        tick();
        scene_rgb = 12'h0BB; text_hit = 1'b1; text_addr = 16'h0000;
        tick();
        scene_rgb = 12'h0CC; text_hit = 1'b0; text_addr = 16'h0F00;
        tick();
        check("mix_text", 16'(rgb1), 16'hF00);
        idle_px();
        tick();
        check("mix_key", 16'(rgb1), 16'h0BB);
        tick();
        check("mix_nohit", 16'(rgb1), 16'h0CC);
        tick();
        check("mix_blank", 16'(rgb1), 16'h000);

        // Switch to win: restart delay; no mid-frame change.
        over = 2'b11;
        tick();
        check("win_midframe_hold", 16'(on1), 16'h1);
        frame(); check("win_delay_f1", 16'(on1), 16'h0);
        frame(); check("win_delay_f2", 16'(on1), 16'h0);
        frame(); check("win_show_f3", 16'(on1), 16'h1);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("win_blink_%0d", i), 16'(on1), 16'(blink_exp[i]));
        end

        // Back to gameover: restart delay, then steady visibility.
        over = 2'b10;
        tick();
        frame(); check("go2_delay_f1", 16'(on1), 16'h0);
        frame(); check("go2_delay_f2", 16'(on1), 16'h0);
        frame(); check("go2_show_f3", 16'(on1), 16'h1);
        for (int i = 0; i < 3; i++) begin
            frame();
            check($sformatf("go2_steady_%0d", i), 16'(on1), 16'h1);
        end

        // Pixel stream with text_hit toggling every pixel at both ROM latencies.
        for (int j = 0; j < 12; j++) begin
            if (j < 8) begin
                de_in = 1'b1;
                text_addr = 16'(16'h0100 + j);
                scene_rgb = 12'(12'h800 + j);
                text_hit = j[0];
            end else begin
                idle_px();
            end
            tick();
            if (j >= 2 && j < 10) check($sformatf("lat2_px%0d", j - 2), 16'(rgb1), 16'(px_exp(j - 2)));
            else if (j == 1) check("lat2_pre", 16'(rgb1), 16'h000);
            if (j >= 4) check($sformatf("lat4_px%0d", j - 4), 16'(rgb3), 16'(px_exp(j - 4)));
            else if (j == 3) check("lat4_pre", 16'(rgb3), 16'h000);
        end

        // over[1] falling: visibility drops at the next frame_start, not mid-frame.
        over = 2'b00;
        tick();
        check("off_midframe_hold", 16'(on1), 16'h1);
        frame(); check("off_fs", 16'(on1), 16'h0);
        frame(); check("off_idle", 16'(on1), 16'h0);

        // Re-enter SHOW, then asynchronous reset mid-frame with active pixels.
        over = 2'b10;
        tick();
        frame(); frame(); frame();
        check("re_show", 16'(on1), 16'h1);
        de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1; scene_rgb = 12'h123;
        tick(); tick(); tick();
        check("pre_rst_rgb", 16'(rgb1), 16'h123);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rgb", 16'(rgb1), 16'h000);
        check("async_rst_de", 16'(de1), 16'h0);
        check("async_rst_hs", 16'(hs1), 16'h0);
        check("async_rst_vs", 16'(vs1), 16'h0);
        check("async_rst_text_on", 16'(on1), 16'h0);
        check("async_rst_rgb_lat3", 16'(rgb3), 16'h000);
        rst_n = 1'b1;
        tick();
        frame(); check("post_rst_f1", 16'(on1), 16'h0);
        frame(); check("post_rst_f2", 16'(on1), 16'h0);
        frame(); check("post_rst_f3", 16'(on1), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_overlay_mixer.md
Name: text_overlay_mixer

Overview:
- Downstream consumer of the text address mapper in the VGA path.
- Takes the mapped text-image address for each pixel and issues it to the synchronous text ROM.
- Delays the scene pixel and sync signals to match the ROM latency, then overlays opaque text pixels on the scene.
- Gates overlay visibility with a frame-synchronous state machine (entry delay, optional blink), driven by the game-over/win status.

Parameters:
- ADDR_W, 16, width of text ROM address.
- ROM_LAT, 1, text ROM read latency in clocks (legal range 1..3).
- KEY_COLOR, 12'h000, ROM colour treated as transparent.
- DELAY_FRAMES, 30, frames between over[1] rising and text becoming visible.
- BLINK_FRAMES, 16, frames per on/off half-period (blink build only).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- over  in  2  0x: scene; 10: gameover; 11: win
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- de_in  in  1  active-display flag for the current pixel
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- scene_rgb  in  12  scene pixel colour
- text_hit  in  1  current pixel lies inside the text rectangle
- text_addr  in  ADDR_W  mapped text ROM address
- rom_addr  out  ADDR_W  registered address to text ROM
- rom_data  in  12  ROM colour, valid ROM_LAT clocks after rom_addr
- rgb_out  out  12  mixed pixel
- de_out  out  1  delayed de_in
- hs_out  out  1  delayed hs_in
- vs_out  out  1  delayed vs_in
- text_on  out  1  overlay currently visible

Behaviour:
- One clock domain. Reset is asynchronous, active-low on rst_n, and takes effect immediately.
- Reset values: rom_addr=0, rgb_out=0, de_out=0, hs_out=0, vs_out=0, text_on=0, state=IDLE, frame counter=0, all pipeline stages=0.
- Pipeline: inputs are sampled at edge N, and rom_addr is updated at N. Outputs for that pixel appear after edge N+ROM_LAT+1, so total latency is L=ROM_LAT+1 clocks.
- de, hs, vs, scene_rgb, text_hit and a snapshot of text_on travel through an L-deep shift register that stays aligned with rom_data.
- Mix at output stage, in priority order:
  - if !de_d, rgb_out=0;
  - else if text_on_d && text_hit_d && rom_data!=KEY_COLOR, rgb_out=rom_data;
  - else rgb_out=scene_d.
- State machine; states are IDLE, DELAY, SHOW. kind is a latched copy of over[0].
  - IDLE: when over[1]=1, latch kind=over[0], clear counter, go to DELAY.
  - DELAY: on each frame_start, counter+1. When the counter reaches DELAY_FRAMES-1 and frame_start=1, go to SHOW and clear the counter. DELAY_FRAMES=0 or 1 enters SHOW on the first frame_start.
  - SHOW: hold. The counter is used only for blink.
  - From any state, over[1]=0 forces IDLE and clears the counter on the next edge.
  - In DELAY/SHOW, over[0]!=kind re-latches kind, returns to DELAY and clears the counter (restart).
- text_on changes only on a frame_start cycle. It is set to 1 iff the next state is SHOW and the blink phase is on. It is never changed mid-frame, so there is no tearing.
- Exception: over[1] falling clears text_on at the next frame_start, not immediately.
- Counter width is clog2(max(DELAY_FRAMES,2*BLINK_FRAMES))+1. The counter saturates rather than wraps in DELAY.
- frame_start and a state change in the same cycle: the transition is taken and text_on is evaluated with the new state.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- Defined: in SHOW with kind=1 (win), the counter increments on each frame_start and wraps at 2*BLINK_FRAMES-1.
  - Blink phase is on for counts 0..BLINK_FRAMES-1 and off otherwise.
  - Gameover (kind=0) text is steady.
- Undefined: blink logic and the BLINK_FRAMES comparison are removed, and the SHOW phase is always on.

Test Plan:
- Reset mid-frame with de_in=1: assert rst_n=0 → rgb_out, de_out, hs_out, vs_out, text_on all 0 immediately (asynchronously); state=IDLE after release.
- over=00, ROM_LAT=1, scene_rgb=12'hABC, de_in=1 → rgb_out=12'hABC exactly 2 clocks later; hs/vs/de delayed 2 clocks; rom_addr follows text_addr with 1 clock delay.
- over 00→10, DELAY_FRAMES=3 → text_on rises at the 3rd frame_start after entry. Then text_hit=1, rom_data=12'hF00 → rgb_out=12'hF00; rom_data=KEY_COLOR → scene colour.
- In SHOW, over 10→11 → return to DELAY, text_on=0 at next frame_start, SHOW again after 3 more frames; over →00 → text_on=0 at next frame_start, IDLE.
- TEXT_BLINK_EN defined, BLINK_FRAMES=2, over=11 in SHOW → text_on pattern 1,1,0,0,1,1 over successive frame_starts. With over=10 → steady 1.
- ROM_LAT=3: pixel stream with text_hit toggling every pixel → each output pixel uses the rom_data for its own address (latency 4); no off-by-one at rectangle edges.
